// File: rtl/warp_scheduler.sv
// Warp scheduler: kernel launch FIFO feeding a single simd_core through an IDLE/LAUNCH/RUN/REPORT FSM.
// Optional RUN watchdog enabled by defining WARP_SCHED_WATCHDOG_EN. Kernel packing: {warp_id[43:40], thread_count[39:32], start_pc[31:0]}.
module warp_scheduler #(
    parameter int          QUEUE_DEPTH  = 4,
    parameter logic [15:0] WDOG_LIMIT   = 16'd1000,
    parameter int          THREAD_COUNT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         kernel_valid,
    input  logic [43:0]                  kernel_in,
    output logic                         kernel_ready,
    output logic [43:0]                  core_kernel,
    output logic                         core_start,
    input  logic                         core_is_finished,
    input  logic [3:0]                   core_finished_warp_id,
    output logic                         done_valid,
    output logic [3:0]                   done_warp_id,
    output logic                         done_timeout,
    input  logic                         done_ready,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         err_sticky
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [3:0]    IDLE_WID    = 4'hF;
    localparam logic [43:0]   IDLE_KERNEL = {IDLE_WID, 40'd0};
    localparam logic [7:0]    TC_MAX      = 8'(THREAD_COUNT);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(QUEUE_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [43:0]   mem_q [QUEUE_DEPTH];
    logic [43:0]   active_q, active_d;
    logic [43:0]   core_kernel_q, core_kernel_d;
    logic          core_start_q, core_start_d;
    logic [3:0]    done_wid_q, done_wid_d;
    logic          err_q, err_d;

    logic [3:0]  in_wid;
    logic [7:0]  in_tc;
    logic        accept, drop, push, clamp, pop;
    logic [43:0] push_kernel, head;
    logic        finish_hit, finish_bad;

`ifdef WARP_SCHED_WATCHDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        done_to_q, done_to_d;
`else
    logic        unused_wdog;
    assign unused_wdog = ^WDOG_LIMIT;
`endif

    always_comb begin
        kernel_ready = (count_q != FULL_COUNT);
        in_wid       = kernel_in[43:40];
        in_tc        = kernel_in[39:32];
        // Reserved idle id is consumed by the handshake but never reaches the queue.
        accept       = rst && kernel_valid && kernel_ready;
        drop         = accept && (in_wid == IDLE_WID);
        push         = accept && !drop;
        clamp        = push && (in_tc > TC_MAX);
        push_kernel  = {in_wid, clamp ? TC_MAX : in_tc, kernel_in[31:0]};
        head         = mem_q[rd_ptr_q];
        pop          = (state_q == S_LAUNCH);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        core_start_d  = 1'b0;
        core_kernel_d = IDLE_KERNEL;
        done_wid_d    = done_wid_q;
        err_d         = err_q | drop | clamp;
        finish_hit    = 1'b0;
        finish_bad    = 1'b0;
`ifdef WARP_SCHED_WATCHDOG_EN
        wdog_d        = wdog_q;
        done_to_d     = done_to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                active_d = head;
`ifdef WARP_SCHED_WATCHDOG_EN
                wdog_d    = '0;
                done_to_d = 1'b0;
`endif
                // Zero-thread kernels have no work for the core; report them directly.
                if (head[39:32] == 8'd0) begin
                    state_d    = S_REPORT;
                    done_wid_d = head[43:40];
                end else begin
                    state_d       = S_RUN;
                    core_start_d  = 1'b1;
                    core_kernel_d = head;
                end
            end
            S_RUN: begin
                core_kernel_d = active_q;
                finish_hit    = core_is_finished && (core_finished_warp_id == active_q[43:40]);
                finish_bad    = core_is_finished && (core_finished_warp_id != active_q[43:40]);
                err_d         = err_d | finish_bad;
`ifdef WARP_SCHED_WATCHDOG_EN
                wdog_d = wdog_q + 16'd1;
`endif
                if (finish_hit) begin
                    state_d       = S_REPORT;
                    done_wid_d    = active_q[43:40];
                    core_kernel_d = IDLE_KERNEL;
                end
`ifdef WARP_SCHED_WATCHDOG_EN
                else if (wdog_d == WDOG_LIMIT) begin
                    state_d       = S_REPORT;
                    done_wid_d    = active_q[43:40];
                    done_to_d     = 1'b1;
                    err_d         = 1'b1;
                    core_kernel_d = IDLE_KERNEL;
                end
`endif
            end
            S_REPORT: begin
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            core_start_q  <= 1'b0;
            core_kernel_q <= IDLE_KERNEL;
            done_wid_q    <= 4'd0;
            err_q         <= 1'b0;
`ifdef WARP_SCHED_WATCHDOG_EN
            wdog_q        <= 16'd0;
            done_to_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            core_start_q  <= core_start_d;
            core_kernel_q <= core_kernel_d;
            done_wid_q    <= done_wid_d;
            err_q         <= err_d;
`ifdef WARP_SCHED_WATCHDOG_EN
            wdog_q        <= wdog_d;
            done_to_q     <= done_to_d;
`endif
        end
    end

    // Queue storage and the active kernel are pure data; only control state is reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_kernel;
        active_q <= active_d;
    end

    assign core_kernel  = core_kernel_q;
    assign core_start   = core_start_q;
    assign done_valid   = (state_q == S_REPORT);
    assign done_warp_id = done_wid_q;
    assign busy         = (state_q != S_IDLE);
    assign queue_count  = count_q;
    assign err_sticky   = err_q;
`ifdef WARP_SCHED_WATCHDOG_EN
    assign done_timeout = done_to_q;
`else
    assign done_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler: directed scenarios plus randomized traffic against a FIFO-order model.
module tb_warp_scheduler;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        kernel_valid;
    logic [43:0] kernel_in;
    logic        kernel_ready;
    logic [43:0] core_kernel;
    logic        core_start;
    logic        core_is_finished;
    logic [3:0]  core_finished_warp_id;
    logic        done_valid;
    logic [3:0]  done_warp_id;
    logic        done_timeout;
    logic        done_ready;
    logic        busy;
    logic [2:0]  queue_count;
    logic        err_sticky;

    always #5 clk = ~clk;

    warp_scheduler #(.QUEUE_DEPTH(QD), .WDOG_LIMIT(16'd8), .THREAD_COUNT(32)) dut (
        .clk(clk), .rst(rst), .kernel_valid(kernel_valid), .kernel_in(kernel_in),
        .kernel_ready(kernel_ready), .core_kernel(core_kernel), .core_start(core_start),
        .core_is_finished(core_is_finished), .core_finished_warp_id(core_finished_warp_id),
        .done_valid(done_valid), .done_warp_id(done_warp_id), .done_timeout(done_timeout),
        .done_ready(done_ready), .busy(busy), .queue_count(queue_count), .err_sticky(err_sticky)
    );

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          starts = 0;
    logic [43:0] exp_start[$];
    logic [4:0]  exp_done[$];
    logic        exp_err = 1'b0;
    bit          mon_en = 1'b0;
    bit          auto_core = 1'b0;

    localparam logic [43:0] IDLE_K = {4'hF, 40'd0};

    function automatic logic [43:0] mk(input logic [3:0] w, input logic [7:0] tc, input logic [31:0] pc);
        return {w, tc, pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: dispatch and completion follow acceptance order; clamp to 32 threads.
    task automatic model_push(input logic [43:0] k);
        logic [3:0] w;
        logic [7:0] tc;
        w  = k[43:40];
        tc = k[39:32];
        if (w == 4'hF) begin
            exp_err = 1'b1;
            return;
        end
        if (tc > 8'd32) begin
            tc = 8'd32;
            exp_err = 1'b1;
        end
        if (tc != 8'd0) exp_start.push_back({w, tc, k[31:0]});
        exp_done.push_back({1'b0, w});
    endtask

    task automatic push(input logic [43:0] k);
        kernel_in = k;
        kernel_valid = 1'b1;
        model_push(k);
        tick();
        kernel_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [43:0] k);
        logic r;
        logic acc;
        acc = 1'b0;
        kernel_in = k;
        kernel_valid = 1'b1;
        for (int c = 0; c < 300 && !acc; c++) begin
            r = kernel_ready;
            tick();
            if (r) acc = 1'b1;
        end
        kernel_valid = 1'b0;
        chk("push_accepted", 64'(acc), 64'(1));
        if (acc) model_push(k);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        kernel_valid = 1'b0;
        core_is_finished = 1'b0;
        exp_start.delete();
        exp_done.delete();
        exp_err = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            if (exp_done.size() == 0 && exp_start.size() == 0 && !busy) ok = 1'b1;
            else tick();
        end
        chk("drain_complete", 64'(ok), 64'(1));
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (mon_en) begin
            if (core_start === 1'b1) begin
                starts++;
                if (exp_start.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_core_start: kernel 0x%0h, none expected", core_kernel);
                end else chk("core_kernel", 64'(core_kernel), 64'(exp_start.pop_front()));
            end
            if (done_valid === 1'b1 && done_ready === 1'b1) begin
                if (exp_done.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: warp %0d, none expected", done_warp_id);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_warp_id", 64'(done_warp_id), 64'(e[3:0]));
                    chk("done_timeout", 64'(done_timeout), 64'(e[4]));
                end
            end
        end
    end

    // Core responder: finishes each started warp after a short random delay, sometimes with a wrong id first.
    initial begin
        logic [3:0] w;
        int d;
        forever begin
            @(negedge clk);
            if (auto_core && core_start === 1'b1) begin
                w = core_kernel[43:40];
                d = $urandom_range(0, 3);
                tick();
                repeat (d) tick();
                if ($urandom_range(0, 3) == 0) begin
                    core_finished_warp_id = w ^ 4'h1;
                    core_is_finished = 1'b1;
                    exp_err = 1'b1;
                    tick();
                end
                core_finished_warp_id = w;
                core_is_finished = 1'b1;
                tick();
                core_is_finished = 1'b0;
            end
        end
    end

    initial begin
        logic [43:0] k1;
        logic [43:0] k6;
        int s0;
        int cnt;
        logic [3:0] rw;
        logic [7:0] rtc;
        int sel;

        rst = 1'b0;
        kernel_valid = 1'b0;
        kernel_in = '0;
        core_is_finished = 1'b0;
        core_finished_warp_id = 4'd0;
        done_ready = 1'b0;
        do_reset();
        mon_en = 1'b1;

        @(negedge clk);
        chk("rst_kernel_ready", 64'(kernel_ready), 64'(1));
        chk("rst_core_start", 64'(core_start), 64'(0));
        chk("rst_core_kernel", 64'(core_kernel), 64'(IDLE_K));
        chk("rst_done_valid", 64'(done_valid), 64'(0));
        chk("rst_done_warp_id", 64'(done_warp_id), 64'(0));
        chk("rst_done_timeout", 64'(done_timeout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err_sticky), 64'(0));
        chk("rst_queue_count", 64'(queue_count), 64'(0));

        // Launch latency and single-cycle start pulse
        k1 = mk(4'd1, 8'd4, 32'h1234_5678);
        push(k1);
        @(negedge clk);
        chk("lat_e0_start", 64'(core_start), 64'(0));
        chk("lat_e0_count", 64'(queue_count), 64'(1));
        tick();
        @(negedge clk);
        chk("lat_e1_start", 64'(core_start), 64'(0));
        chk("lat_e1_busy", 64'(busy), 64'(1));
        tick();
        @(negedge clk);
        chk("lat_e2_start", 64'(core_start), 64'(1));
        chk("lat_e2_kernel", 64'(core_kernel), 64'(k1));
        chk("lat_e2_busy", 64'(busy), 64'(1));
        tick();
        @(negedge clk);
        chk("lat_e3_start", 64'(core_start), 64'(0));
        chk("run_kernel_held", 64'(core_kernel), 64'(k1));

        // Mismatched finish ignored, matching finish reports and holds
        core_finished_warp_id = 4'd2;
        core_is_finished = 1'b1;
        tick();
        @(negedge clk);
        chk("bad_id_err", 64'(err_sticky), 64'(1));
        chk("bad_id_no_done", 64'(done_valid), 64'(0));
        core_finished_warp_id = 4'd1;
        tick();
        core_is_finished = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_done_valid", 64'(done_valid), 64'(1));
            chk("hold_done_wid", 64'(done_warp_id), 64'(1));
            chk("report_kernel_idle", 64'(core_kernel), 64'(IDLE_K));
            tick();
        end
        done_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("post_report_done_valid", 64'(done_valid), 64'(0));
        chk("post_report_busy", 64'(busy), 64'(0));
        done_ready = 1'b0;

        // Queue fills behind a running warp; fifth push stalls; FIFO dispatch order
        do_reset();
        push(mk(4'd1, 8'd4, 32'h0000_1000));
        tick();
        tick();
        for (int i = 0; i < 4; i++) push(mk(4'(i + 2), 8'(i + 1), $urandom));
        @(negedge clk);
        chk("full_ready_low", 64'(kernel_ready), 64'(0));
        chk("full_count", 64'(queue_count), 64'(QD));
        k6 = mk(4'd6, 8'd7, $urandom);
        kernel_in = k6;
        kernel_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("stall_count", 64'(queue_count), 64'(QD));
        core_finished_warp_id = 4'd1;
        core_is_finished = 1'b1;
        done_ready = 1'b1;
        tick();
        core_is_finished = 1'b0;
        auto_core = 1'b1;
        push_wait(k6);
        wait_drain();
        auto_core = 1'b0;
        done_ready = 1'b0;

        // Reserved id dropped; zero-thread kernel reports without a start; oversize clamped
        do_reset();
        push(mk(4'hF, 8'd4, 32'hDEAD_0000));
        @(negedge clk);
        chk("drop_count", 64'(queue_count), 64'(0));
        chk("drop_err", 64'(err_sticky), 64'(1));
        s0 = starts;
        done_ready = 1'b1;
        push(mk(4'd3, 8'd0, 32'h0000_0040));
        wait_drain();
        chk("tc0_no_start", 64'(starts), 64'(s0));
        do_reset();
        auto_core = 1'b1;
        push(mk(4'd9, 8'd200, 32'h0000_0080));
        wait_drain();
        chk("clamp_err", 64'(err_sticky), 64'(1));
        auto_core = 1'b0;

        // Reset mid-run with kernels queued
        do_reset();
        done_ready = 1'b1;
        push(mk(4'd1, 8'd4, 32'h0000_0100));
        tick();
        tick();
        push(mk(4'd2, 8'd4, 32'h0000_0200));
        push(mk(4'd3, 8'd4, 32'h0000_0300));
        @(negedge clk);
        chk("midrun_count", 64'(queue_count), 64'(2));
        chk("midrun_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        exp_start.delete();
        exp_done.delete();
        kernel_in = mk(4'd5, 8'd4, 32'h0);
        kernel_valid = 1'b1;
        core_finished_warp_id = 4'd1;
        core_is_finished = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_count", 64'(queue_count), 64'(0));
        chk("midrst_core_kernel", 64'(core_kernel), 64'(IDLE_K));
        chk("midrst_done_valid", 64'(done_valid), 64'(0));
        chk("midrst_err", 64'(err_sticky), 64'(0));
        tick();
        kernel_valid = 1'b0;
        core_is_finished = 1'b0;
        rst = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("after_rst_busy", 64'(busy), 64'(0));
        chk("after_rst_count", 64'(queue_count), 64'(0));
        done_ready = 1'b0;

`ifdef WARP_SCHED_WATCHDOG_EN
        // Warp that never finishes is reported as a timeout after WDOG_LIMIT RUN cycles
        do_reset();
        push(mk(4'd7, 8'd4, 32'h0000_0700));
        void'(exp_done.pop_back());
        exp_done.push_back({1'b1, 4'd7});
        cnt = 0;
        while (core_start !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (done_valid !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("wdog_run_cycles", 64'(cnt), 64'(8));
        chk("wdog_timeout_flag", 64'(done_timeout), 64'(1));
        chk("wdog_err", 64'(err_sticky), 64'(1));
        tick();
        done_ready = 1'b1;
        wait_drain();
        done_ready = 1'b0;
`endif

        // Randomized traffic
        do_reset();
        auto_core = 1'b1;
        for (int i = 0; i < 200; i++) begin
            done_ready = ($urandom_range(0, 3) != 0);
            if (kernel_ready && $urandom_range(0, 1) == 1) begin
                rw  = 4'($urandom_range(0, 15));
                sel = $urandom_range(0, 9);
                if (sel == 0) rtc = 8'd0;
                else if (sel == 1) rtc = 8'($urandom_range(33, 255));
                else rtc = 8'($urandom_range(1, 32));
                push(mk(rw, rtc, $urandom));
            end else tick();
        end
        kernel_valid = 1'b0;
        done_ready = 1'b1;
        wait_drain();
        chk("rand_err_sticky", 64'(err_sticky), 64'(exp_err));
        chk("rand_queue_empty", 64'(queue_count), 64'(0));
        auto_core = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, meaning kernel queue entries (power of two, >=2).
REQ-002 SHALL have parameter WDOG_LIMIT, default 16'd1000, meaning max RUN cycles per warp (used only with REQ-026).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports kernel_valid  input  1  and kernel_in  input  kernel_t  for a kernel launch request.
REQ-006 SHALL have port kernel_ready  output  1  meaning queue can accept this cycle.
REQ-007 SHALL have ports core_kernel  output  kernel_t  and core_start  output  1  as the dispatch to simd_core.
REQ-008 SHALL have ports core_is_finished  input  1  and core_finished_warp_id  input  4  from simd_core.
REQ-009 SHALL have ports done_valid  output  1, done_warp_id  output  4, done_timeout  output  1, and done_ready  input  1  as the completion report.
REQ-010 SHALL have ports busy  output  1, queue_count  output  $clog2(QUEUE_DEPTH)+1, and err_sticky  output  1.

Function
REQ-011 SHALL accept a kernel when kernel_valid && kernel_ready; kernel_ready = queue not full; no full-queue bypass.
REQ-012 SHALL drop accepted kernels with warp_id 4'hF (reserved idle id), without enqueueing, and set err_sticky.
REQ-013 SHALL clamp enqueued thread_count to THREAD_COUNT when larger, setting err_sticky.
REQ-014 SHALL implement FSM IDLE, LAUNCH, RUN, REPORT; busy = state != IDLE.
REQ-015 IDLE: SHALL move to LAUNCH when queue_count != 0.
REQ-016 LAUNCH: SHALL pop the head into an active register, drive core_start=1 for exactly this one cycle, and move to RUN; a kernel with thread_count 0 instead goes to REPORT with no core_start.
REQ-017 SHALL drive core_kernel from the active register in LAUNCH and RUN; otherwise warp_id=4'hF, thread_count=0, start_pc=0.
REQ-018 RUN: SHALL move to REPORT when core_is_finished && core_finished_warp_id == active warp_id; a finish with a mismatched id SHALL be ignored and set err_sticky.
REQ-019 REPORT: SHALL hold done_valid=1 with stable done_warp_id/done_timeout until done_ready, then move to IDLE on that edge.
REQ-020 SHALL give latency: kernel accepted on edge N into an empty queue with the FSM in IDLE -> core_start high in the cycle following edge N+2.
REQ-021 SHALL let enqueue proceed in every state; a simultaneous push and pop leaves queue_count unchanged; queue pointers wrap modulo QUEUE_DEPTH.
REQ-022 SHALL clear err_sticky only by reset.

Reset
REQ-023 SHALL on rst==0 at a clock edge: state IDLE, queue empty, queue_count 0, kernel_ready 1 from the next cycle, core_start 0, core_kernel idle value, done_valid 0, done_warp_id 0, done_timeout 0, busy 0, err_sticky 0, watchdog 0.
REQ-024 SHALL abandon an in-flight warp and discard queued kernels on reset mid-operation, with no done report for them.
REQ-025 SHALL ignore kernel_valid and core_is_finished while rst==0.

Configuration
REQ-026 With WARP_SCHED_WATCHDOG_EN defined: SHALL count cycles in RUN (cleared on LAUNCH); when the count reaches WDOG_LIMIT it SHALL go to REPORT with done_timeout=1 and set err_sticky.
REQ-027 Without WARP_SCHED_WATCHDOG_EN: no counter; done_timeout tied 0; RUN exits only per REQ-018.

Verification
REQ-028 Push {warp 1, 4 thr, pc 32'h1234_5678} after reset -> core_start one pulse 2 edges later, core_kernel matches, busy=1.
REQ-029 In RUN, finish with id 2 then id 1 -> id 2 ignored with err_sticky=1; id 1 gives done_valid, done_warp_id=1; held while done_ready=0 for 3 cycles.
REQ-030 Push 5 kernels back-to-back while warp 1 runs -> kernel_ready low after 4th, 5th stalls; kernels dispatched in FIFO order.
REQ-031 Push warp_id 4'hF and a thread_count 0 kernel -> first dropped, err_sticky=1; second reports done with no core_start.
REQ-032 Assert rst=0 during RUN with 2 queued -> next edge all outputs at reset values, queue_count 0, no done report.
REQ-033 With WARP_SCHED_WATCHDOG_EN, WDOG_LIMIT=8, never finish -> done_valid with done_timeout=1 after 8 RUN cycles.
